// File: rtl/cluster_bus_isolate_ctrl.sv
// cluster_bus_isolate_ctrl: per-port AXI isolation and outstanding-transaction limiter
package cluster_bus_isolate_pkg;

  typedef struct packed {
    logic [3:0]  aw_id;
    logic [31:0] aw_addr;
    logic        aw_valid;
    logic [31:0] w_data;
    logic        w_last;
    logic        w_valid;
    logic        b_ready;
    logic [3:0]  ar_id;
    logic [31:0] ar_addr;
    logic        ar_valid;
    logic        r_ready;
  } axi_req_t;

  typedef struct packed {
    logic        aw_ready;
    logic        w_ready;
    logic [3:0]  b_id;
    logic [1:0]  b_resp;
    logic        b_valid;
    logic        ar_ready;
    logic [3:0]  r_id;
    logic [31:0] r_data;
    logic [1:0]  r_resp;
    logic        r_last;
    logic        r_valid;
  } axi_resp_t;

endpackage

module cluster_bus_isolate_ctrl #(
  parameter int unsigned MaxTxns        = 8,
  parameter bit          IsolateOnReset = 1'b0,
  parameter type         axi_req_t      = cluster_bus_isolate_pkg::axi_req_t,
  parameter type         axi_resp_t     = cluster_bus_isolate_pkg::axi_resp_t,
  localparam int unsigned CntWidth      = $clog2(MaxTxns + 1)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                isolate_i,
  output logic                isolated_o,
  input  axi_req_t            slv_req_i,
  output axi_resp_t           slv_resp_o,
  output axi_req_t            mst_req_o,
  input  axi_resp_t           mst_resp_i,
  output logic [CntWidth-1:0] wr_outstanding_o,
  output logic [CntWidth-1:0] rd_outstanding_o
);

  typedef enum logic [1:0] {PASS, DRAIN, ISOLATED} state_t;

  localparam logic [CntWidth-1:0] Max = CntWidth'(MaxTxns);
  localparam state_t ResetState = IsolateOnReset ? ISOLATED : PASS;

  state_t state, state_next;
  logic [CntWidth-1:0] wr_cnt, rd_cnt, wr_next, rd_next;
  logic allow_aw, allow_ar, aw_hs, ar_hs, b_hs, r_hs;

  assign allow_aw = (state == PASS) && (wr_cnt < Max);
  assign allow_ar = (state == PASS) && (rd_cnt < Max);

  // Everything passes straight through except the address valid/ready pairs
  always_comb begin
    mst_req_o           = slv_req_i;
    mst_req_o.aw_valid  = slv_req_i.aw_valid & allow_aw;
    mst_req_o.ar_valid  = slv_req_i.ar_valid & allow_ar;
    slv_resp_o          = mst_resp_i;
    slv_resp_o.aw_ready = mst_resp_i.aw_ready & allow_aw;
    slv_resp_o.ar_ready = mst_resp_i.ar_ready & allow_ar;
  end

  assign aw_hs = mst_req_o.aw_valid & mst_resp_i.aw_ready;
  assign ar_hs = mst_req_o.ar_valid & mst_resp_i.ar_ready;
  assign b_hs  = mst_resp_i.b_valid & slv_req_i.b_ready;
  assign r_hs  = mst_resp_i.r_valid & slv_req_i.r_ready & mst_resp_i.r_last;

  // A stray response at zero leaves the counter at zero instead of wrapping
  assign wr_next = (aw_hs && !b_hs) ? wr_cnt + 1'b1 :
                   (b_hs && !aw_hs && wr_cnt != '0) ? wr_cnt - 1'b1 : wr_cnt;
  assign rd_next = (ar_hs && !r_hs) ? rd_cnt + 1'b1 :
                   (r_hs && !ar_hs && rd_cnt != '0) ? rd_cnt - 1'b1 : rd_cnt;

  // Next state: release of isolate_i beats drain completion, which looks at next-cycle counts
  always_comb begin
    state_next = state;
    case (state)
      PASS:     state_next = isolate_i ? DRAIN : PASS;
      DRAIN:    state_next = !isolate_i ? PASS :
                             (wr_next == '0 && rd_next == '0) ? ISOLATED : DRAIN;
      ISOLATED: state_next = isolate_i ? ISOLATED : PASS;
      default:  state_next = ResetState;
    endcase
  end

  // State and outstanding counters
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state  <= ResetState;
      wr_cnt <= '0;
      rd_cnt <= '0;
    end else begin
      state  <= state_next;
      wr_cnt <= wr_next;
      rd_cnt <= rd_next;
    end
  end

  assign isolated_o       = (state == ISOLATED);
  assign wr_outstanding_o = wr_cnt;
  assign rd_outstanding_o = rd_cnt;

`ifndef SYNTHESIS
  assert property (@(posedge clk_i) disable iff (!rst_ni) !(b_hs && !aw_hs && wr_cnt == '0));
  assert property (@(posedge clk_i) disable iff (!rst_ni) !(r_hs && !ar_hs && rd_cnt == '0));
  assert property (@(posedge clk_i) disable iff (!rst_ni)
    ($past(mst_req_o.aw_valid & ~mst_resp_i.aw_ready) && slv_req_i.aw_valid && state == PASS)
    |-> mst_req_o.aw_valid);
  assert property (@(posedge clk_i) disable iff (!rst_ni)
    ($past(mst_req_o.ar_valid & ~mst_resp_i.ar_ready) && slv_req_i.ar_valid && state == PASS)
    |-> mst_req_o.ar_valid);
`endif

endmodule

// File: tb/tb_cluster_bus_isolate_ctrl.sv
// tb_cluster_bus_isolate_ctrl: two configurations checked every cycle against a transaction-level model
module tb_cluster_bus_isolate_ctrl;
  import cluster_bus_isolate_pkg::*;

  localparam int MAXT [2] = '{8, 4};
  localparam bit IOR  [2] = '{1'b0, 1'b1};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic iso [2];
  axi_req_t  slv_req [2];
  axi_resp_t slv_resp [2];
  axi_req_t  mst_req [2];
  axi_resp_t mresp [2];
  logic isolated0, isolated1;
  logic [3:0] wr0, rd0;
  logic [2:0] wr1, rd1;

  int tests = 0;
  int fails = 0;
  int m_wr [2];
  int m_rd [2];
  bit m_pass [2];
  bit m_iso [2];

  always #5 clk = ~clk;

  cluster_bus_isolate_ctrl #(.MaxTxns(8), .IsolateOnReset(1'b0)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .isolate_i(iso[0]), .isolated_o(isolated0),
    .slv_req_i(slv_req[0]), .slv_resp_o(slv_resp[0]), .mst_req_o(mst_req[0]), .mst_resp_i(mresp[0]),
    .wr_outstanding_o(wr0), .rd_outstanding_o(rd0)
  );

  cluster_bus_isolate_ctrl #(.MaxTxns(4), .IsolateOnReset(1'b1)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .isolate_i(iso[1]), .isolated_o(isolated1),
    .slv_req_i(slv_req[1]), .slv_resp_o(slv_resp[1]), .mst_req_o(mst_req[1]), .mst_resp_i(mresp[1]),
    .wr_outstanding_o(wr1), .rd_outstanding_o(rd1)
  );

  task automatic cmp(string name, int d, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, d, act, exp, $time);
    end
  endtask

  function automatic int wr_of(int d);
    return d == 0 ? int'(wr0) : int'(wr1);
  endfunction

  function automatic int rd_of(int d);
    return d == 0 ? int'(rd0) : int'(rd1);
  endfunction

  function automatic int iso_of(int d);
    return d == 0 ? int'(isolated0) : int'(isolated1);
  endfunction

  task automatic model_reset(int d);
    m_wr[d] = 0;
    m_rd[d] = 0;
    m_pass[d] = !IOR[d];
    m_iso[d] = IOR[d];
  endtask

  // Address traffic flows only when the last sampled isolate was low and the cap is not reached;
  // the port is isolated once isolation has been held across two samples with nothing in flight.
  task automatic model_step(int d);
    bit aw_ok, ar_ok;
    int awh, arh, bh, rh;
    aw_ok = m_pass[d] && m_wr[d] < MAXT[d];
    ar_ok = m_pass[d] && m_rd[d] < MAXT[d];
    awh = int'(slv_req[d].aw_valid && mresp[d].aw_ready && aw_ok);
    arh = int'(slv_req[d].ar_valid && mresp[d].ar_ready && ar_ok);
    bh  = int'(mresp[d].b_valid && slv_req[d].b_ready);
    rh  = int'(mresp[d].r_valid && mresp[d].r_last && slv_req[d].r_ready);
    m_wr[d] = m_wr[d] + awh - bh;
    m_rd[d] = m_rd[d] + arh - rh;
    m_iso[d] = iso[d] && !m_pass[d] && m_wr[d] == 0 && m_rd[d] == 0;
    m_pass[d] = !iso[d];
  endtask

  task automatic check_dut(int d);
    bit aw_ok, ar_ok;
    aw_ok = m_pass[d] && m_wr[d] < MAXT[d];
    ar_ok = m_pass[d] && m_rd[d] < MAXT[d];
    cmp("mst_aw_valid", d, 64'(mst_req[d].aw_valid), 64'(slv_req[d].aw_valid && aw_ok));
    cmp("slv_aw_ready", d, 64'(slv_resp[d].aw_ready), 64'(mresp[d].aw_ready && aw_ok));
    cmp("mst_ar_valid", d, 64'(mst_req[d].ar_valid), 64'(slv_req[d].ar_valid && ar_ok));
    cmp("slv_ar_ready", d, 64'(slv_resp[d].ar_ready), 64'(mresp[d].ar_ready && ar_ok));
    cmp("isolated", d, 64'(iso_of(d)), 64'(m_iso[d]));
    cmp("wr_outstanding", d, 64'(wr_of(d)), 64'(m_wr[d]));
    cmp("rd_outstanding", d, 64'(rd_of(d)), 64'(m_rd[d]));
    cmp("w_data_pass", d, 64'(mst_req[d].w_data), 64'(slv_req[d].w_data));
    cmp("w_valid_pass", d, 64'(mst_req[d].w_valid), 64'(slv_req[d].w_valid));
    cmp("r_data_pass", d, 64'(slv_resp[d].r_data), 64'(mresp[d].r_data));
    cmp("b_valid_pass", d, 64'(slv_resp[d].b_valid), 64'(mresp[d].b_valid));
  endtask

  // Inputs are already set at the falling edge; check, take one rising edge, land on the next falling edge
  task automatic step();
    #1;
    check_dut(0);
    check_dut(1);
    @(posedge clk);
    model_step(0);
    model_step(1);
    @(negedge clk);
  endtask

  task automatic drive(int d, bit aw, bit ar, bit b, bit r);
    slv_req[d] = '0;
    mresp[d] = '0;
    slv_req[d].aw_valid = aw;
    mresp[d].aw_ready = aw;
    slv_req[d].ar_valid = ar;
    mresp[d].ar_ready = ar;
    mresp[d].b_valid = b;
    slv_req[d].b_ready = b;
    mresp[d].r_valid = r;
    mresp[d].r_last = r;
    slv_req[d].r_ready = r;
  endtask

  // Responses are only offered while the model says something is in flight
  task automatic rand_drive(int d);
    slv_req[d] = '0;
    mresp[d] = '0;
    slv_req[d].aw_valid = 1'($urandom_range(1));
    slv_req[d].aw_addr = $urandom;
    slv_req[d].w_data = $urandom;
    slv_req[d].w_valid = 1'($urandom_range(1));
    slv_req[d].ar_valid = 1'($urandom_range(1));
    slv_req[d].b_ready = 1'($urandom_range(1));
    slv_req[d].r_ready = 1'($urandom_range(1));
    mresp[d].aw_ready = 1'($urandom_range(1));
    mresp[d].ar_ready = 1'($urandom_range(1));
    mresp[d].b_valid = m_wr[d] > 0 && $urandom_range(3) == 0;
    mresp[d].r_valid = m_rd[d] > 0 && $urandom_range(2) == 0;
    mresp[d].r_last = 1'($urandom_range(1));
    mresp[d].r_data = $urandom;
    if ($urandom_range(31) == 0) iso[d] = !iso[d];
  endtask

  task automatic random_phase(int n);
    for (int i = 0; i < n; i++) begin
      rand_drive(0);
      rand_drive(1);
      step();
    end
  endtask

  initial begin
    iso[0] = 1'b0;
    iso[1] = 1'b1;
    drive(0, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 0);
    model_reset(0);
    model_reset(1);
    @(negedge clk);
    @(negedge clk);
    cmp("reset_isolated", 0, 64'(isolated0), 64'd0);
    cmp("reset_isolated", 1, 64'(isolated1), 64'd1);
    cmp("reset_wr", 0, 64'(wr0), 64'd0);
    cmp("reset_rd", 1, 64'(rd1), 64'd0);
    rst_n = 1'b1;
    step();
    step();
    cmp("iso_on_reset_aw_blocked", 1, 64'(slv_resp[1].aw_ready), 64'd0);
    cmp("iso_on_reset_isolated", 1, 64'(isolated1), 64'd1);
    iso[1] = 1'b0;
    step();
    cmp("release_isolated", 1, 64'(isolated1), 64'd0);
    cmp("release_aw_ready", 1, 64'(slv_resp[1].aw_ready), 64'd1);
    step();
    cmp("release_aw_count", 1, 64'(wr1), 64'd1);
    drive(1, 0, 0, 0, 0);

    iso[0] = 1'b1;
    cmp("idle_iso_c0", 0, 64'(isolated0), 64'd0);
    step();
    cmp("idle_iso_c1", 0, 64'(isolated0), 64'd0);
    step();
    cmp("idle_iso_c2", 0, 64'(isolated0), 64'd1);
    iso[0] = 1'b0;
    drive(0, 1, 0, 0, 0);
    step();
    cmp("deiso_isolated", 0, 64'(isolated0), 64'd0);
    cmp("deiso_aw_ready", 0, 64'(slv_resp[0].aw_ready), 64'd1);
    step();
    cmp("deiso_aw_count", 0, 64'(wr0), 64'd1);
    drive(0, 0, 0, 1, 0);
    step();

    drive(0, 1, 1, 0, 0);
    step();
    step();
    drive(0, 1, 0, 0, 0);
    step();
    cmp("drain_wr_setup", 0, 64'(wr0), 64'd3);
    cmp("drain_rd_setup", 0, 64'(rd0), 64'd2);
    drive(0, 0, 0, 0, 0);
    iso[0] = 1'b1;
    step();
    drive(0, 1, 1, 0, 0);
    cmp("drain_aw_blocked", 0, 64'(slv_resp[0].aw_ready), 64'd0);
    cmp("drain_ar_blocked", 0, 64'(slv_resp[0].ar_ready), 64'd0);
    step();
    cmp("drain_wr_held", 0, 64'(wr0), 64'd3);
    drive(0, 0, 0, 1, 0);
    step();
    step();
    step();
    drive(0, 0, 0, 0, 1);
    cmp("drain_not_done", 0, 64'(isolated0), 64'd0);
    step();
    step();
    cmp("drain_done", 0, 64'(isolated0), 64'd1);

    iso[0] = 1'b0;
    drive(0, 0, 0, 0, 0);
    step();
    drive(0, 1, 1, 0, 0);
    step();
    step();
    drive(0, 1, 1, 1, 1);
    step();
    cmp("simul_wr", 0, 64'(wr0), 64'd2);
    cmp("simul_rd", 0, 64'(rd0), 64'd2);

    drive(0, 0, 0, 1, 0);
    step();
    step();
    drive(0, 0, 0, 0, 1);
    step();
    drive(0, 0, 0, 0, 0);
    iso[0] = 1'b1;
    step();
    cmp("abort_draining", 0, 64'(isolated0), 64'd0);
    step();
    cmp("abort_still_draining", 0, 64'(isolated0), 64'd0);
    iso[0] = 1'b0;
    drive(0, 0, 1, 0, 0);
    step();
    cmp("abort_isolated", 0, 64'(isolated0), 64'd0);
    cmp("abort_ar_ready", 0, 64'(slv_resp[0].ar_ready), 64'd1);
    step();
    cmp("abort_ar_count", 0, 64'(rd0), 64'd2);
    drive(0, 0, 0, 0, 0);

    drive(1, 0, 1, 0, 0);
    step();
    step();
    step();
    step();
    cmp("limit_rd", 1, 64'(rd1), 64'd4);
    cmp("limit_ar_blocked", 1, 64'(slv_resp[1].ar_ready), 64'd0);
    step();
    cmp("limit_rd_held", 1, 64'(rd1), 64'd4);
    drive(1, 0, 1, 0, 1);
    step();
    cmp("limit_rd_after_r", 1, 64'(rd1), 64'd3);
    drive(1, 0, 1, 0, 0);
    cmp("limit_ar_reopen", 1, 64'(slv_resp[1].ar_ready), 64'd1);
    step();
    cmp("limit_rd_refill", 1, 64'(rd1), 64'd4);
    drive(1, 0, 0, 0, 0);

    random_phase(2000);

    #2;
    rst_n = 1'b0;
    #1;
    cmp("async_rst_wr", 0, 64'(wr0), 64'd0);
    cmp("async_rst_rd", 0, 64'(rd0), 64'd0);
    cmp("async_rst_wr", 1, 64'(wr1), 64'd0);
    cmp("async_rst_rd", 1, 64'(rd1), 64'd0);
    cmp("async_rst_isolated", 1, 64'(isolated1), 64'd1);
    model_reset(0);
    model_reset(1);
    iso[0] = 1'b0;
    iso[1] = 1'b0;
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    random_phase(1500);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
